// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-digit blink and whole-display flash.
// The frame (codes, blink mask, flash) is latched once per scan so digits never tear.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink_en,
  input  logic        flash,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [19:0]   FRAME_BLANK = {4{5'd19}};

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [19:0]   frame_ssd_q, frame_ssd_d;
  logic [3:0]    frame_blink_q, frame_blink_d;
  logic          frame_flash_q, frame_flash_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          ref_tc;
  logic          blink_tc;
  logic          frame_tc;
  logic          supp;
  logic [4:0]    code;

  // Segment patterns {a,b,c,d,e,f,g}, active-low; unused codes are blank.
  function automatic logic [6:0] decode(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = 7'b0000001;
      5'd1:    s = 7'b1001111;
      5'd2:    s = 7'b0010010;
      5'd3:    s = 7'b0000110;
      5'd4:    s = 7'b1001100;
      5'd5:    s = 7'b0100100;
      5'd6:    s = 7'b0100000;
      5'd7:    s = 7'b0001111;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0000100;
      5'd10:   s = 7'b0110001;
      5'd11:   s = 7'b1110001;
      5'd12:   s = 7'b0100100;
      5'd13:   s = 7'b1000010;
      5'd14:   s = 7'b0000001;
      5'd15:   s = 7'b0011000;
      5'd16:   s = 7'b0110000;
      5'd17:   s = 7'b1101010;
      5'd18:   s = 7'b1111110;
      5'd20:   s = 7'b1100000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    ref_tc   = (ref_cnt_q == REF_LAST);
    blink_tc = (blink_cnt_q == BLINK_LAST);
    frame_tc = ref_tc && (idx_q == 2'd3);

    ref_cnt_d   = ref_tc ? '0 : ref_cnt_q + RW'(1);
    idx_d       = ref_tc ? idx_q + 2'd1 : idx_q;
    blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_tc;

    frame_ssd_d   = frame_tc ? ssd      : frame_ssd_q;
    frame_blink_d = frame_tc ? blink_en : frame_blink_q;
    frame_flash_d = frame_tc ? flash    : frame_flash_q;

    case (idx_q)
      2'd0:    code = frame_ssd_q[19:15];
      2'd1:    code = frame_ssd_q[14:10];
      2'd2:    code = frame_ssd_q[9:5];
      default: code = frame_ssd_q[4:0];
    endcase

    // Outputs follow the current index, so they trail an index change by one clock.
    supp  = phase_q && (frame_flash_q || frame_blink_q[2'd3 - idx_q]);
    an_d  = supp ? 4'b1111 : ~(4'b1000 >> idx_q);
    seg_d = supp ? 7'b1111111 : decode(code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      idx_q         <= 2'd0;
      phase_q       <= 1'b0;
      frame_ssd_q   <= FRAME_BLANK;
      frame_blink_q <= 4'b0000;
      frame_flash_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      frame_ssd_q   <= frame_ssd_d;
      frame_blink_q <= frame_blink_d;
      frame_flash_q <= frame_flash_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign AN        = an_q;
  assign seven_out = seg_q;

endmodule
